shift_add_mul: RTL and testbench
================================

# shift_add_mul

Parametrised serial shift-add multiplier that retires RADIX_BITS multiplier bits per clock and supports unsigned or two's-complement operands. Operands are accepted through a valid/ready input handshake, and the full-width product is returned through a valid/ready output handshake. The block is the general-purpose multiply engine of the large-multiplication datapath; its defaults give a 1024×256 unsigned multiply at one bit per cycle.

## Interface
- A_W, 1024, multiplicand width in bits (≥2)
- B_W, 256, multiplier width in bits (≥2; must be a multiple of RADIX_BITS)
- RADIX_BITS, 1, multiplier bits retired per cycle (1, 2 or 4)
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort; returns block to IDLE
- in_valid  in  1  operands a, b, tc are valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  A_W  multiplicand
- b  in  B_W  multiplier
- tc  in  1  1 = operands and product are two's complement; 0 = unsigned
- out_valid  out  1  product is valid (high only in DONE)
- out_ready  in  1  consumer accepts product
- product  out  A_W+B_W  result; held stable while out_valid=1
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Let N = B_W/RADIX_BITS.
- IDLE: in_ready=1. On in_valid=1 at a clock edge:
  - capture tc;
  - capture |a| and |b| (magnitudes when tc=1, raw values when tc=0);
  - set neg = tc & (a[A_W-1] ^ b[B_W-1]);
  - clear partial-sum register P (A_W bits) and step counter;
  - move to RUN.
- Magnitude of the most-negative value, −2^(W−1), is 2^(W−1), which fits in W unsigned bits. No overflow is possible.
- RUN, one step per cycle:
  - d = low RADIX_BITS of shift register Q (initialised to |b|);
  - s = P + d·|a|, width A_W+RADIX_BITS;
  - P ← s >> RADIX_BITS;
  - Q ← {s[RADIX_BITS-1:0], Q[B_W-1:RADIX_BITS]};
  - counter increments.
- After step N: product ← neg ? −{P,Q} : {P,Q}, taken modulo 2^(A_W+B_W). State moves to DONE.
- DONE: out_valid=1 and product is held. On out_ready=1 at an edge the state moves to IDLE; out_valid drops and product is retained.
- in_valid in RUN or DONE is ignored; operands are not queued.
- a, b and tc may change freely after capture without affecting the result.
- flush=1 at an edge, in any state:
  - state goes to IDLE;
  - out_valid=0;
  - P, Q, counter and product are cleared;
  - flush overrides in_valid and out_ready in the same cycle.
- rstn low at any time, including mid-RUN: immediately IDLE, P=Q=0, counter=0, product=0, out_valid=0. After release, in_ready=1 and busy=0.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, product=0.
- Input handshake completes at edge t0, where in_valid=1 in IDLE.
- RUN steps occur at edges t0+1 … t0+N.
- out_valid rises after edge t0+N, so latency is N cycles from the accept edge.
- Output handshake completes at the first edge t1 ≥ t0+N+1 with out_ready=1. in_ready=1 after edge t1.
- Minimum initiation interval is N+2 cycles (out_ready held high). Default parameters give 258.
- out_valid and in_ready are never high in the same cycle.
- busy = !in_ready.
- product changes only at entry to DONE, at flush and at reset.

## Test plan
- A_W=B_W=8, R=2, tc=0, a=255, b=255:
  - product=0xFE01;
  - out_valid first high after edge t0+4;
  - in_ready low for exactly 5 cycles with out_ready=1.
- A_W=B_W=8, R=2, tc=1, a=0x80 (−128), b=0x7F (127) → product=0xC080.
- Same configuration, a=0x80, b=0x80 → product=0x4000.
- Same configuration, a=0 or b=0 → product=0.
- Defaults, tc=0:
  - a=2^1024−1, b=2^256−1 → product=(2^1024−1)(2^256−1);
  - out_valid after edge t0+256.
- A_W=B_W=8, R=4, a=0x12, b=0x34:
  - hold out_ready=0 for 10 cycles → product=0x03A8 held stable, in_valid pulses ignored;
  - out_ready=1 → IDLE next cycle.
- Reset and flush interrupts:
  - assert rstn=0 mid-RUN → all outputs return to reset values without a clock edge;
  - flush mid-RUN → in_ready=1 next cycle;
  - a new multiply after either interrupt gives the correct result.

Source files
------------

// File: rtl/shift_add_mul.sv
// Serial shift-add multiplier, RADIX_BITS multiplier bits per cycle,
// unsigned or two's-complement operands, valid/ready on both sides.
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready_o high
// S_RUN  | one shift-add step per cycle, N steps in total
// S_DONE | product valid, waiting for out_ready_i
module shift_add_mul #(
  parameter int A_W        = 1024,
  parameter int B_W        = 256,
  parameter int RADIX_BITS = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [A_W-1:0]     a_i,
  input  logic [B_W-1:0]     b_i,
  input  logic               tc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [A_W+B_W-1:0] product_o,
  output logic               busy_o
);

  localparam int N     = B_W / RADIX_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int P_W   = A_W + RADIX_BITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [A_W-1:0]     a_mag_q, a_mag_d;
  logic [A_W-1:0]     p_q, p_d;
  logic [B_W-1:0]     q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [A_W+B_W-1:0] product_q, product_d;

  logic [P_W-1:0]     step_sum;
  logic [A_W-1:0]     p_step;
  logic [B_W-1:0]     q_step;
  logic [A_W+B_W-1:0] full_mag;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush wins over both handshakes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid_i) state_d = S_RUN;
      S_RUN:  if (cnt_q == LAST) state_d = S_DONE;
      S_DONE: if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    out_valid_o = (state_q == S_DONE);
    busy_o      = (state_q != S_IDLE);
  end

  // One radix step: add the selected multiples of |a| without a wide multiplier
  always_comb begin
    step_sum = {{RADIX_BITS{1'b0}}, p_q};
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (q_q[i]) step_sum = step_sum + ({{RADIX_BITS{1'b0}}, a_mag_q} << i);
    end
  end

  assign p_step = step_sum[P_W-1:RADIX_BITS];

  // Low sum bits shift into the top of Q as the multiplier bits drain out the bottom
  generate
    if (B_W == RADIX_BITS) begin : g_q_full
      assign q_step = step_sum[RADIX_BITS-1:0];
    end else begin : g_q_shift
      assign q_step = {step_sum[RADIX_BITS-1:0], q_q[B_W-1:RADIX_BITS]};
    end
  endgenerate

  assign full_mag = {p_step, q_step};

  // Datapath next-state: capture on accept, step in RUN, clear on flush
  always_comb begin
    a_mag_d   = a_mag_q;
    p_d       = p_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (flush_i) begin
      p_d       = '0;
      q_d       = '0;
      cnt_d     = '0;
      product_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            // -(most negative) wraps to 2^(W-1), which is the correct unsigned magnitude
            a_mag_d = (tc_i && a_i[A_W-1]) ? -a_i : a_i;
            q_d     = (tc_i && b_i[B_W-1]) ? -b_i : b_i;
            neg_d   = tc_i & (a_i[A_W-1] ^ b_i[B_W-1]);
            p_d     = '0;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          p_d   = p_step;
          q_d   = q_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) product_d = neg_q ? -full_mag : full_mag;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_mag_q   <= '0;
      p_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      a_mag_q   <= a_mag_d;
      p_q       <= p_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Bench for shift_add_mul: two 8x8 instances (radix 2 and radix 4) and one
// default 1024x256 instance, checked against plain signed/unsigned arithmetic.
module tb_shift_add_mul;

  logic clk;
  logic rstn;
  logic flush;

  logic [7:0]  sa [2];
  logic [7:0]  sb [2];
  logic        stc [2];
  logic        siv [2];
  logic        sor [2];
  logic        srdy [2];
  logic        sov [2];
  logic        sbusy [2];
  logic [15:0] sprod [2];

  logic [1023:0] ba;
  logic [255:0]  bb;
  logic          btc, biv, bor, brdy, bov, bbusy;
  logic [1279:0] bprod;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_mul #(.A_W(8), .B_W(8), .RADIX_BITS(2)) u_r2 (
    .clk(clk), .rstn(rstn), .flush_i(flush),
    .in_valid_i(siv[0]), .in_ready_o(srdy[0]),
    .a_i(sa[0]), .b_i(sb[0]), .tc_i(stc[0]),
    .out_valid_o(sov[0]), .out_ready_i(sor[0]),
    .product_o(sprod[0]), .busy_o(sbusy[0]));

  shift_add_mul #(.A_W(8), .B_W(8), .RADIX_BITS(4)) u_r4 (
    .clk(clk), .rstn(rstn), .flush_i(flush),
    .in_valid_i(siv[1]), .in_ready_o(srdy[1]),
    .a_i(sa[1]), .b_i(sb[1]), .tc_i(stc[1]),
    .out_valid_o(sov[1]), .out_ready_i(sor[1]),
    .product_o(sprod[1]), .busy_o(sbusy[1]));

  shift_add_mul u_big (
    .clk(clk), .rstn(rstn), .flush_i(flush),
    .in_valid_i(biv), .in_ready_o(brdy),
    .a_i(ba), .b_i(bb), .tc_i(btc),
    .out_valid_o(bov), .out_ready_i(bor),
    .product_o(bprod), .busy_o(bbusy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1279:0] got, input logic [1279:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_small(input logic [7:0] a, input logic [7:0] b, input logic tc);
    logic signed [15:0] x, y;
    if (tc) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = {8'h00, a};
      y = {8'h00, b};
    end
    return 16'(x * y);
  endfunction

  function automatic logic [1279:0] ref_big(input logic [1023:0] a, input logic [255:0] b, input logic tc);
    logic signed [1279:0] x, y;
    if (tc) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = {256'd0, a};
      y = {1024'd0, b};
    end
    return 1280'(x * y);
  endfunction

  // One multiply on small instance k; hold>0 keeps out_ready low that many cycles in DONE
  task automatic small_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic tc, input logic [15:0] exp, input int hold);
    int n    = (k == 0) ? 4 : 2;
    int lat  = -1;
    int low  = 0;
    int held = 0;
    int j    = 0;
    @(negedge clk);
    check("idle_rdy", srdy[k], 1'b1);
    sa[k] = a; sb[k] = b; stc[k] = tc; siv[k] = 1'b1; sor[k] = (hold == 0);
    @(posedge clk);
    #1;
    siv[k] = 1'b0;
    sa[k]  = 8'($urandom); sb[k] = 8'($urandom); stc[k] = 1'($urandom);
    while (j < 100) begin
      @(negedge clk);
      if (srdy[k]) break;
      low++;
      if (sov[k] && lat < 0) begin
        lat = j;
        check("product", sprod[k], exp);
      end
      if (sov[k] && hold > 0 && !sor[k]) begin
        check("held_prod", sprod[k], exp);
        check("held_rdy", srdy[k], 1'b0);
        if (held < hold) begin
          siv[k] = 1'($urandom);
          sa[k]  = 8'($urandom);
          held++;
        end else begin
          siv[k] = 1'b0;
          sor[k] = 1'b1;
        end
      end
      j++;
    end
    check("latency", 32'(lat), 32'(n));
    if (hold == 0) check("rdy_low_cycles", 32'(low), 32'(n + 1));
    check("ov_after", sov[k], 1'b0);
    check("busy_after", sbusy[k], 1'b0);
    check("prod_kept", sprod[k], exp);
    sor[k] = 1'b0;
  endtask

  task automatic big_op(input logic [1023:0] a, input logic [255:0] b, input logic tc);
    logic [1279:0] exp = ref_big(a, b, tc);
    int lat = -1;
    int j   = 0;
    @(negedge clk);
    ba = a; bb = b; btc = tc; biv = 1'b1; bor = 1'b1;
    @(posedge clk);
    #1;
    biv = 1'b0; ba = '0; bb = '0;
    while (j < 400) begin
      @(negedge clk);
      if (bov) begin
        lat = j;
        break;
      end
      j++;
    end
    check("big_latency", 32'(lat), 32'd256);
    check("big_product", bprod, exp);
    @(negedge clk);
    check("big_rdy_after", brdy, 1'b1);
  endtask

  initial begin
    logic [1023:0] ra;
    logic [255:0]  rb;
    logic [7:0]    xa, xb;
    logic          xt;

    rstn = 1'b0; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sa[k] = '0; sb[k] = '0; stc[k] = 1'b0; siv[k] = 1'b0; sor[k] = 1'b0;
    end
    ba = '0; bb = '0; btc = 1'b0; biv = 1'b0; bor = 1'b0;

    #12;
    check("rst_rdy", srdy[0], 1'b1);
    check("rst_ov", sov[0], 1'b0);
    check("rst_busy", sbusy[0], 1'b0);
    check("rst_prod", sprod[0], 16'h0);
    check("rst_big_rdy", brdy, 1'b1);
    check("rst_big_prod", bprod, '0);
    @(negedge clk);
    rstn = 1'b1;

    small_op(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    small_op(0, 8'h80, 8'h7F, 1'b1, 16'hC080, 0);
    small_op(0, 8'h80, 8'h80, 1'b1, 16'h4000, 0);
    small_op(0, 8'h00, 8'h9C, 1'b1, 16'h0000, 0);
    small_op(0, 8'h37, 8'h00, 1'b0, 16'h0000, 0);
    small_op(1, 8'h12, 8'h34, 1'b0, 16'h03A8, 10);

    for (int i = 0; i < 24; i++) begin
      xa = 8'($urandom); xb = 8'($urandom); xt = 1'($urandom);
      small_op(i % 2, xa, xb, xt, ref_small(xa, xb, xt), (i % 5 == 0) ? 3 : 0);
    end

    // asynchronous reset in the middle of a run
    @(negedge clk);
    sa[0] = 8'h5A; sb[0] = 8'hC3; stc[0] = 1'b0; siv[0] = 1'b1;
    @(posedge clk);
    #1 siv[0] = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_rdy", srdy[0], 1'b1);
    check("arst_ov", sov[0], 1'b0);
    check("arst_busy", sbusy[0], 1'b0);
    check("arst_prod", sprod[0], 16'h0);
    @(negedge clk);
    rstn = 1'b1;
    small_op(0, 8'h5A, 8'hC3, 1'b1, ref_small(8'h5A, 8'hC3, 1'b1), 0);

    // flush in the middle of a run
    @(negedge clk);
    sa[1] = 8'hA7; sb[1] = 8'h3E; stc[1] = 1'b1; siv[1] = 1'b1;
    @(posedge clk);
    #1 siv[1] = 1'b0;
    @(negedge clk);
    check("pre_flush_busy", sbusy[1], 1'b1);
    flush = 1'b1; sor[1] = 1'b1;
    @(negedge clk);
    flush = 1'b0; sor[1] = 1'b0;
    check("flush_rdy", srdy[1], 1'b1);
    check("flush_ov", sov[1], 1'b0);
    check("flush_prod", sprod[1], 16'h0);
    small_op(1, 8'hA7, 8'h3E, 1'b1, ref_small(8'hA7, 8'h3E, 1'b1), 0);

    big_op({1024{1'b1}}, {256{1'b1}}, 1'b0);
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 32; w++) ra[w*32 +: 32] = $urandom;
      for (int w = 0; w < 8; w++)  rb[w*32 +: 32] = $urandom;
      big_op(ra, rb, 1'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
